sram_2rw_arbiter: RTL and testbench

Shares one 2RW 32x128 SRAM macro (two active-low RW ports, inputs captured at posedge, array access at negedge) among NUM_REQ requesters. It sits directly in front of the macro and sequences it. After reset it clears the array to zero, then grants up to two requests per cycle with round-robin fairness. It blocks same-cycle address hazards between the two ports and returns read data with fixed latency.

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_2rw_arbiter_rr_pick2.sv | 49 ++++
 rtl/sram_2rw_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sram_2rw_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the 2RW SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 7;
    localparam int unsigned INIT_WORDS     = 128;
    localparam int unsigned MAX_REQ        = 8;
    localparam int unsigned TRK_ID_W       = $clog2(MAX_REQ);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    // One in-flight access on a macro port: read flag plus requester id.
    typedef struct packed {
        logic                rd;
        logic [TRK_ID_W-1:0] id;
    } trk_entry_t;

endpackage

// File: rtl/sram_2rw_arbiter_rr_pick2.sv
// Round-robin dual picker: first two valid requesters from ptr, with the
// same-address write hazard dropping the second grant.
module rr_pick2 #(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned ADDR_WIDTH = 7,
    localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [IDX_W-1:0]              ptr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ-1:0]            we,
    output logic                          a_valid_c,
    output logic [IDX_W-1:0]              a_idx_c,
    output logic                          b_valid_c,
    output logic [IDX_W-1:0]              b_idx_c
);

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [IDX_W-1:0]      idx;

    always_comb begin
        a_valid_c = 1'b0;
        a_idx_c   = '0;
        b_valid_c = 1'b0;
        b_idx_c   = '0;
        idx       = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            addr_arr[i] = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = IDX_W'((int'(ptr) + k) % int'(NUM_REQ));
            if (req[idx]) begin
                if (!a_valid_c) begin
                    a_valid_c = 1'b1;
                    a_idx_c   = idx;
                end else if (!b_valid_c) begin
                    b_valid_c = 1'b1;
                    b_idx_c   = idx;
                end
            end
        end
        // Same word on both ports is only safe when both are reads.
        if (a_valid_c && b_valid_c && (addr_arr[a_idx_c] == addr_arr[b_idx_c])
            && (we[a_idx_c] || we[b_idx_c])) begin
            b_valid_c = 1'b0;
        end
    end

endmodule

// File: rtl/sram_2rw_arbiter.sv
// Front-end for a 2RW SRAM macro: clears the array after reset, then grants
// up to two requesters per cycle and returns read data two cycles later.
module sram_2rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
    output logic                          init_done,
    output logic                          csb0,
    output logic                          web0,
    output logic [ADDR_WIDTH-1:0]         addr0,
    output logic [DATA_WIDTH-1:0]         din0,
    input  logic [DATA_WIDTH-1:0]         dout0,
    output logic                          csb1,
    output logic                          web1,
    output logic [ADDR_WIDTH-1:0]         addr1,
    output logic [DATA_WIDTH-1:0]         din1,
    input  logic [DATA_WIDTH-1:0]         dout1
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(INIT_WORDS / 2);

    arb_state_e                    state_q, state_d;
    logic [CNT_W-1:0]              init_cnt_q;
    logic [IDX_W-1:0]              rr_ptr_q;
    logic                          init_done_q;
    trk_entry_t                    trk0_q, trk1_q, trk0_d, trk1_d;
    logic [NUM_REQ-1:0]            rsp_valid_q;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata_q;

    logic                  a_valid_c, b_valid_c;
    logic [IDX_W-1:0]      a_idx_c, b_idx_c;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    rr_pick2 #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .addr      (req_addr),
        .we        (req_we),
        .a_valid_c (a_valid_c),
        .a_idx_c   (a_idx_c),
        .b_valid_c (b_valid_c),
        .b_idx_c   (b_idx_c)
    );

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next state, grant handshake and macro port drive.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        csb0      = 1'b1;
        web0      = 1'b1;
        addr0     = '0;
        din0      = '0;
        csb1      = 1'b1;
        web1      = 1'b1;
        addr1     = '0;
        din1      = '0;
        trk0_d    = '0;
        trk1_d    = '0;
        if (!rst) begin
            case (state_q)
                INIT: begin
                    csb0  = 1'b0;
                    web0  = 1'b0;
                    addr0 = ADDR_WIDTH'({init_cnt_q, 1'b0});
                    csb1  = 1'b0;
                    web1  = 1'b0;
                    addr1 = ADDR_WIDTH'({init_cnt_q, 1'b1});
                    if (init_cnt_q == CNT_W'(INIT_WORDS / 2 - 1)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (a_valid_c) begin
                        req_ready[a_idx_c] = 1'b1;
                        csb0      = 1'b0;
                        web0      = ~req_we[a_idx_c];
                        addr0     = addr_arr[a_idx_c];
                        din0      = wdata_arr[a_idx_c];
                        trk0_d.rd = ~req_we[a_idx_c];
                        trk0_d.id = TRK_ID_W'(a_idx_c);
                    end
                    if (b_valid_c) begin
                        req_ready[b_idx_c] = 1'b1;
                        csb1      = 1'b0;
                        web1      = ~req_we[b_idx_c];
                        addr1     = addr_arr[b_idx_c];
                        din1      = wdata_arr[b_idx_c];
                        trk1_d.rd = ~req_we[b_idx_c];
                        trk1_d.id = TRK_ID_W'(b_idx_c);
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            init_done_q <= 1'b0;
            trk0_q      <= '0;
            trk1_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            init_done_q <= (state_d == RUN);
            trk0_q      <= trk0_d;
            trk1_q      <= trk1_d;
            if (state_q == INIT) begin
                init_cnt_q <= init_cnt_q + CNT_W'(1);
            end
            if (state_q == RUN) begin
                if (b_valid_c) begin
                    rr_ptr_q <= ptr_after(b_idx_c);
                end else if (a_valid_c) begin
                    rr_ptr_q <= ptr_after(a_idx_c);
                end
            end
            // Macro output is valid one cycle after capture; route it by id.
            rsp_valid_q <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (trk0_q.rd && (trk0_q.id == TRK_ID_W'(i))) begin
                    rsp_valid_q[i] <= 1'b1;
                    rsp_rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= dout0;
                end else if (trk1_q.rd && (trk1_q.id == TRK_ID_W'(i))) begin
                    rsp_valid_q[i] <= 1'b1;
                    rsp_rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= dout1;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_2rw_arbiter.sv
// Directed vector bench for sram_2rw_arbiter with a behavioural 2RW macro.
module tb_sram_2rw_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_we;
    logic [27:0]  req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   rsp_valid;
    logic [127:0] rsp_rdata;
    logic         init_done;
    logic         csb0, web0, csb1, web1;
    logic [6:0]   addr0, addr1;
    logic [31:0]  din0, din1, dout0, dout1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_2rw_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0),
        .csb1      (csb1),
        .web1      (web1),
        .addr1     (addr1),
        .din1      (din1),
        .dout1     (dout1)
    );

    // Macro model: capture at posedge, access the array at negedge.
    logic [31:0] mem [128];
    logic        mem_init = 1'b0;
    logic        csb0_q, web0_q, csb1_q, web1_q;
    logic [6:0]  addr0_q, addr1_q;
    logic [31:0] din0_q, din1_q;

    always @(posedge clk) begin
        csb0_q  <= csb0;
        web0_q  <= web0;
        addr0_q <= addr0;
        din0_q  <= din0;
        csb1_q  <= csb1;
        web1_q  <= web1;
        addr1_q <= addr1;
        din1_q  <= din1;
    end

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
            mem_init <= 1'b1;
        end else begin
            if (!csb0_q) begin
                if (!web0_q) mem[addr0_q] <= din0_q;
                else         dout0 <= mem[addr0_q];
            end
            if (!csb1_q) begin
                if (!web1_q) mem[addr1_q] <= din1_q;
                else         dout1 <= mem[addr1_q];
            end
        end
    end

    typedef struct packed {
        logic [3:0]   valid;
        logic [3:0]   we;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [3:0]   exp_ready;
        logic [3:0]   exp_rsp;
        logic [127:0] exp_rdata;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mkv(input logic [3:0] v, input logic [3:0] we,
                                 input logic [6:0] a0, input logic [6:0] a1,
                                 input logic [6:0] a2, input logic [6:0] a3,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [3:0] er, input logic [3:0] ers,
                                 input logic [31:0] r0, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] r3);
        vec_t x;
        x.valid     = v;
        x.we        = we;
        x.addr      = {a3, a2, a1, a0};
        x.wdata     = {64'h0, w1, w0};
        x.exp_ready = er;
        x.exp_rsp   = ers;
        x.exp_rdata = {r3, r2, r1, r0};
        return x;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        req_valid = v.valid;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        localparam logic [31:0] DB = 32'hDEAD_BEEF;
        localparam logic [31:0] C1 = 32'h1234_5678;
        localparam logic [31:0] CF = 32'hCAFE_F00D;
        vecs[0]  = mkv(4'b1111, 4'b0000, 0, 1, 127, 127, 0,  0,  4'b0011, 4'b0000, 0,  0,  0,  0);
        vecs[1]  = mkv(4'b1100, 4'b0000, 0, 1, 127, 127, 0,  0,  4'b1100, 4'b0000, 0,  0,  0,  0);
        vecs[2]  = mkv(4'b0011, 4'b0011, 5, 6, 0,   0,   DB, C1, 4'b0011, 4'b0011, 0,  0,  0,  0);
        vecs[3]  = mkv(4'b0011, 4'b0000, 5, 6, 0,   0,   0,  0,  4'b0011, 4'b1100, 0,  0,  0,  0);
        vecs[4]  = mkv(4'b0011, 4'b0001, 9, 9, 0,   0,   CF, 0,  4'b0001, 4'b0000, 0,  0,  0,  0);
        vecs[5]  = mkv(4'b0010, 4'b0000, 9, 9, 0,   0,   0,  0,  4'b0010, 4'b0011, DB, C1, 0,  0);
        vecs[6]  = mkv(4'b0011, 4'b0000, 9, 9, 0,   0,   0,  0,  4'b0011, 4'b0000, 0,  0,  0,  0);
        vecs[7]  = mkv(4'b0000, 4'b0000, 0, 0, 0,   0,   0,  0,  4'b0000, 4'b0010, 0,  CF, 0,  0);
        vecs[8]  = mkv(4'b0000, 4'b0000, 0, 0, 0,   0,   0,  0,  4'b0000, 4'b0011, CF, CF, 0,  0);
        vecs[9]  = mkv(4'b1000, 4'b0000, 0, 0, 0,   10,  0,  0,  4'b1000, 4'b0000, 0,  0,  0,  0);
        vecs[10] = mkv(4'b1111, 4'b0000, 5, 6, 9,   127, 0,  0,  4'b0011, 4'b0000, 0,  0,  0,  0);
        vecs[11] = mkv(4'b1111, 4'b0000, 5, 6, 9,   127, 0,  0,  4'b1100, 4'b1000, 0,  0,  0,  0);
        vecs[12] = mkv(4'b1111, 4'b0000, 5, 6, 9,   127, 0,  0,  4'b0011, 4'b0011, DB, C1, 0,  0);
        vecs[13] = mkv(4'b1111, 4'b0000, 5, 6, 9,   127, 0,  0,  4'b1100, 4'b1100, 0,  0,  CF, 0);
        vecs[14] = mkv(4'b1111, 4'b0000, 5, 6, 9,   127, 0,  0,  4'b0011, 4'b0011, DB, C1, 0,  0);
        vecs[15] = mkv(4'b1111, 4'b0000, 5, 6, 9,   127, 0,  0,  4'b1100, 4'b1100, 0,  0,  CF, 0);
        vecs[16] = mkv(4'b0000, 4'b0000, 0, 0, 0,   0,   0,  0,  4'b0000, 4'b0011, DB, C1, 0,  0);
        vecs[17] = mkv(4'b0000, 4'b0000, 0, 0, 0,   0,   0,  0,  4'b0000, 4'b1100, 0,  0,  CF, 0);

        rst = 1'b1;
        apply(vecs[0]);
        repeat (3) begin
            next_cycle();
            @(negedge clk);
            check("rst_ready", 128'(req_ready), 128'(4'b0000));
            check("rst_ctl", 128'({csb0, csb1, web0, web1}), 128'(4'b1111));
            check("rst_addr_din", 128'({addr0, addr1, din0, din1}), 128'(0));
            check("rst_rsp", 128'({rsp_valid, init_done}), 128'(0));
            check("rst_rdata", rsp_rdata, 128'(0));
        end

        // Init clear with every requester already pending.
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            check("init_ready", 128'({req_ready, init_done}), 128'(0));
            check("init_port", 128'({csb0, web0, addr0, din0, csb1, web1, addr1, din1}),
                  128'({1'b0, 1'b0, 7'(2*k), 32'h0, 1'b0, 1'b0, 7'(2*k+1), 32'h0}));
        end

        for (int j = 0; j < NV; j++) begin
            next_cycle();
            apply(vecs[j]);
            @(negedge clk);
            if (j == 0) check("init_done", 128'(init_done), 128'(1));
            check($sformatf("v%0d_ready", j), 128'(req_ready), 128'(vecs[j].exp_ready));
            check($sformatf("v%0d_rsp_valid", j), 128'(rsp_valid), 128'(vecs[j].exp_rsp));
            for (int i = 0; i < 4; i++) begin
                if (vecs[j].exp_rsp[i]) begin
                    check($sformatf("v%0d_rdata%0d", j, i),
                          128'(rsp_rdata[i*32 +: 32]), 128'(vecs[j].exp_rdata[i*32 +: 32]));
                end
            end
        end

        // Reset one cycle after a read is accepted.
        next_cycle();
        apply(mkv(4'b0001, 4'b0000, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("mid_accept", 128'(req_ready), 128'(4'b0001));
        next_cycle();
        rst = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("mid_rst_ready", 128'(req_ready), 128'(0));
        check("mid_rst_csb", 128'({csb0, csb1}), 128'(2'b11));
        next_cycle();
        rst = 1'b0;
        req_valid = 4'b0001;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            check("reinit_ready", 128'({req_ready, init_done}), 128'(0));
            check("reinit_rsp", 128'(rsp_valid), 128'(0));
        end
        next_cycle();
        @(negedge clk);
        check("reinit_done", 128'({init_done, req_ready}), 128'({1'b1, 4'b0001}));
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        check("reinit_rsp_t1", 128'(rsp_valid), 128'(0));
        next_cycle();
        @(negedge clk);
        check("reinit_rsp_t2", 128'(rsp_valid), 128'(4'b0001));
        check("reinit_rdata", 128'(rsp_rdata[31:0]), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
